tenthirty_multi: RTL and testbench

Parametrised ten-and-a-half game engine for N players plus an automatic dealer.
- Successor to the single-player tenthirty block; runs on the board's system clock.
- Takes debounced hit/stand buttons and cards from an external deck source over a valid/req handshake.
- Publishes scores, busts and per-player win flags to the display/LED layer.
- All scores are carried in half-points (10.5 = 21).

---
 rtl/tenthirty_multi.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_tenthirty_multi.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tenthirty_multi.sv
// tenthirty_multi: ten-and-a-half game engine for N players plus an automatic
// dealer. Scores are in half-points; cards arrive over a req/vld handshake.
module tenthirty_multi #(
  parameter int N_PLAYERS         = 2,
  parameter int MAX_CARDS         = 5,
  parameter int TARGET_HALF       = 21,
  parameter int DEALER_STAND_HALF = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btn_m,
  input  logic                     btn_r,
  output logic                     card_req,
  input  logic                     card_vld,
  input  logic [3:0]               card_val,
  output logic                     card_err,
  output logic [2:0]               phase,
  output logic [1:0]               cur_player,
  output logic [N_PLAYERS*7-1:0]   player_score,
  output logic [6:0]               dealer_score,
  output logic [N_PLAYERS*3-1:0]   player_cnt,
  output logic [N_PLAYERS-1:0]     bust,
  output logic                     dealer_bust,
  output logic [N_PLAYERS-1:0]     win,
  output logic                     round_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DEAL   = 3'd1,
    S_PLAY   = 3'd2,
    S_DRAW   = 3'd3,
    S_CHECK  = 3'd4,
    S_DEALER = 3'd5,
    S_RESULT = 3'd6
  } phase_e;

  localparam logic [6:0] TARGET    = 7'(TARGET_HALF);
  localparam logic [6:0] STAND     = 7'(DEALER_STAND_HALF);
  localparam logic [2:0] MAXC      = 3'(MAX_CARDS);
  localparam logic [1:0] LAST      = 2'(N_PLAYERS - 1);
  localparam logic [2:0] DEAL_LAST = 3'(N_PLAYERS);   // deal index of the dealer

  // Ranks 1..13 are playable; anything else is discarded with card_err.
  function automatic logic card_ok(input logic [3:0] v);
    return (v >= 4'd1) && (v <= 4'd13);
  endfunction

  // Half-point value: pips count double, face cards count one half-point.
  function automatic logic [6:0] card_half(input logic [3:0] v);
    logic [6:0] h;
    if (v >= 4'd11) begin
      h = 7'd1;
    end else begin
      h = {2'b00, v, 1'b0};
    end
    return h;
  endfunction

  phase_e                      phase_q, phase_d;
  logic [1:0]                  cur_q, cur_d;
  logic [2:0]                  deal_idx_q, deal_idx_d;
  logic [N_PLAYERS-1:0][6:0]   score_q, score_d;
  logic [N_PLAYERS-1:0][2:0]   cnt_q, cnt_d;
  logic [N_PLAYERS-1:0]        bust_q, bust_d;
  logic [6:0]                  dscore_q, dscore_d;
  logic                        dbust_q, dbust_d;
  logic [N_PLAYERS-1:0]        win_q, win_d;
  logic                        req_q, req_d;
  logic                        err_q, err_d;
  logic                        done_q, done_d;
  logic                        btn_m_q, btn_m_d;
  logic                        btn_r_q, btn_r_d;

  logic                        edge_m_s, edge_r_s, acc_s, ok_s;
  logic [6:0]                  half_s, cur_score_s;
  logic [2:0]                  cur_cnt_s;
  logic                        advance_s, clear_s;

  assign edge_m_s = btn_m & ~btn_m_q;
  assign edge_r_s = btn_r & ~btn_r_q;
  assign acc_s    = req_q & card_vld;
  assign ok_s     = card_ok(card_val);
  assign half_s   = card_half(card_val);

  // Select the score and card count of the player currently acting.
  always_comb begin
    cur_score_s = 7'd0;
    cur_cnt_s   = 3'd0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      cur_score_s = (cur_q == 2'(i)) ? score_q[i] : cur_score_s;
      cur_cnt_s   = (cur_q == 2'(i)) ? cnt_q[i]   : cur_cnt_s;
    end
  end

  // Next-state, card handshake and scoring logic for the round FSM.
  always_comb begin
    phase_d    = phase_q;
    cur_d      = cur_q;
    deal_idx_d = deal_idx_q;
    score_d    = score_q;
    cnt_d      = cnt_q;
    bust_d     = bust_q;
    dscore_d   = dscore_q;
    dbust_d    = dbust_q;
    win_d      = win_q;
    req_d      = req_q;
    err_d      = acc_s & ~ok_s;
    done_d     = 1'b0;
    btn_m_d    = btn_m;
    btn_r_d    = btn_r;
    advance_s  = 1'b0;
    clear_s    = 1'b0;

    case (phase_q)
      S_IDLE: begin
        req_d = 1'b0;
        if (edge_m_s) begin
          clear_s = 1'b1;
        end else begin
          clear_s = 1'b0;
        end
      end
      S_DEAL: begin
        if (req_q) begin
          if (acc_s) begin
            req_d = 1'b0;
            if (ok_s) begin
              if (deal_idx_q == DEAL_LAST) begin
                dscore_d   = half_s;
                phase_d    = S_PLAY;
                cur_d      = 2'd0;
                deal_idx_d = 3'd0;
              end else begin
                for (int i = 0; i < N_PLAYERS; i++) begin
                  if (deal_idx_q == 3'(i)) begin
                    score_d[i] = half_s;
                    cnt_d[i]   = 3'd1;
                  end else begin
                    score_d[i] = score_d[i];
                  end
                end
                deal_idx_d = deal_idx_q + 3'd1;
              end
            end else begin
              // Invalid rank: same recipient asks again after the drop cycle.
              deal_idx_d = deal_idx_q;
            end
          end else begin
            req_d = 1'b1;
          end
        end else begin
          req_d = 1'b1;
        end
      end
      S_PLAY: begin
        req_d = 1'b0;
        if (edge_r_s) begin
          // Stand takes priority over a simultaneous hit.
          advance_s = 1'b1;
        end else if (edge_m_s) begin
          phase_d = S_DRAW;
          req_d   = 1'b1;
        end else begin
          phase_d = S_PLAY;
        end
      end
      S_DRAW: begin
        if (req_q) begin
          if (acc_s) begin
            req_d = 1'b0;
            if (ok_s) begin
              for (int i = 0; i < N_PLAYERS; i++) begin
                if (cur_q == 2'(i)) begin
                  score_d[i] = score_q[i] + half_s;
                  cnt_d[i]   = cnt_q[i] + 3'd1;
                end else begin
                  score_d[i] = score_d[i];
                end
              end
              phase_d = S_CHECK;
            end else begin
              phase_d = S_DRAW;
            end
          end else begin
            req_d = 1'b1;
          end
        end else begin
          req_d = 1'b1;
        end
      end
      S_CHECK: begin
        if (cur_score_s > TARGET) begin
          for (int i = 0; i < N_PLAYERS; i++) begin
            if (cur_q == 2'(i)) begin
              bust_d[i] = 1'b1;
            end else begin
              bust_d[i] = bust_d[i];
            end
          end
          advance_s = 1'b1;
        end else if ((cur_score_s == TARGET) || (cur_cnt_s == MAXC)) begin
          advance_s = 1'b1;
        end else begin
          phase_d = S_PLAY;
        end
      end
      S_DEALER: begin
        if (req_q) begin
          if (acc_s) begin
            req_d = 1'b0;
            if (ok_s) begin
              dscore_d = dscore_q + half_s;
            end else begin
              dscore_d = dscore_q;
            end
          end else begin
            req_d = 1'b1;
          end
        end else if (dscore_q > TARGET) begin
          dbust_d = 1'b1;
          phase_d = S_RESULT;
        end else if (dscore_q < STAND) begin
          req_d = 1'b1;
        end else begin
          phase_d = S_RESULT;
        end
      end
      S_RESULT: begin
        req_d = 1'b0;
        if (edge_m_s) begin
          clear_s = 1'b1;
        end else begin
          clear_s = 1'b0;
        end
      end
      default: begin
        phase_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase

    // Hand control to the next player, the dealer, or straight to the result.
    if (advance_s) begin
      if (cur_q == LAST) begin
        if (&bust_d) begin
          phase_d = S_RESULT;
        end else begin
          phase_d = S_DEALER;
        end
      end else begin
        cur_d   = cur_q + 2'd1;
        phase_d = S_PLAY;
      end
    end else begin
      cur_d = cur_d;
    end

    // New round: wipe the table and start dealing immediately.
    if (clear_s) begin
      score_d    = {N_PLAYERS{7'd0}};
      cnt_d      = {N_PLAYERS{3'd0}};
      bust_d     = {N_PLAYERS{1'b0}};
      win_d      = {N_PLAYERS{1'b0}};
      dscore_d   = 7'd0;
      dbust_d    = 1'b0;
      cur_d      = 2'd0;
      deal_idx_d = 3'd0;
      phase_d    = S_DEAL;
      req_d      = 1'b1;
    end else begin
      deal_idx_d = deal_idx_d;
    end

    // Winners are decided once, on entry to RESULT, then held.
    if ((phase_d == S_RESULT) && (phase_q != S_RESULT)) begin
      done_d = 1'b1;
      for (int i = 0; i < N_PLAYERS; i++) begin
        win_d[i] = ~bust_d[i] &&
                   ((cnt_d[i] == MAXC) || dbust_d || (score_d[i] > dscore_d));
      end
    end else begin
      done_d = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= S_IDLE;
      cur_q      <= 2'd0;
      deal_idx_q <= 3'd0;
      score_q    <= {N_PLAYERS{7'd0}};
      cnt_q      <= {N_PLAYERS{3'd0}};
      bust_q     <= {N_PLAYERS{1'b0}};
      dscore_q   <= 7'd0;
      dbust_q    <= 1'b0;
      win_q      <= {N_PLAYERS{1'b0}};
      req_q      <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      btn_m_q    <= 1'b0;
      btn_r_q    <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      cur_q      <= cur_d;
      deal_idx_q <= deal_idx_d;
      score_q    <= score_d;
      cnt_q      <= cnt_d;
      bust_q     <= bust_d;
      dscore_q   <= dscore_d;
      dbust_q    <= dbust_d;
      win_q      <= win_d;
      req_q      <= req_d;
      err_q      <= err_d;
      done_q     <= done_d;
      btn_m_q    <= btn_m_d;
      btn_r_q    <= btn_r_d;
    end
  end

  assign phase        = phase_q;
  assign cur_player   = cur_q;
  assign player_score = score_q;
  assign dealer_score = dscore_q;
  assign player_cnt   = cnt_q;
  assign bust         = bust_q;
  assign dealer_bust  = dbust_q;
  assign win          = win_q;
  assign card_req     = req_q;
  assign card_err     = err_q;
  assign round_done   = done_q;

endmodule

// File: tb/tb_tenthirty_multi.sv
// Bench for tenthirty_multi: directed scenarios plus random rounds checked
// against a round-level reference model of the game rules.
module tb_tenthirty_multi;
  localparam int NP = 2;
  localparam int DECK = 64;

  logic              clk = 1'b0;
  logic              rst, btn_m, btn_r, card_vld;
  logic [3:0]        card_val;
  logic              card_req, card_err, dealer_bust, round_done;
  logic [2:0]        phase;
  logic [1:0]        cur_player;
  logic [NP*7-1:0]   player_score;
  logic [6:0]        dealer_score;
  logic [NP*3-1:0]   player_cnt;
  logic [NP-1:0]     bust, win;

  tenthirty_multi #(.N_PLAYERS(NP), .MAX_CARDS(5), .TARGET_HALF(21),
                    .DEALER_STAND_HALF(14)) dut (
    .clk(clk), .rst(rst), .btn_m(btn_m), .btn_r(btn_r),
    .card_req(card_req), .card_vld(card_vld), .card_val(card_val),
    .card_err(card_err), .phase(phase), .cur_player(cur_player),
    .player_score(player_score), .dealer_score(dealer_score),
    .player_cnt(player_cnt), .bust(bust), .dealer_bust(dealer_bust),
    .win(win), .round_done(round_done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int rd_cnt, err_cnt;
  int deck_q[$];
  int deck_a[DECK];
  int th[NP];
  int m_s[NP], m_c[NP], m_b[NP], m_w[NP], m_deal_s[NP];
  int m_ds, m_db, m_errs, m_used, m_deal_ds, mi;
  int act_p[$], act_k[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample after the edge, count pulses, act as the deck.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (round_done === 1'b1) rd_cnt++;
    if (card_err === 1'b1) err_cnt++;
    if (card_req === 1'b1 && deck_q.size() > 0) begin
      card_vld = 1'b1;
      card_val = 4'(deck_q.pop_front());
    end else if ($urandom_range(0, 3) == 0) begin
      card_vld = 1'b1;                       // noise while no request: must be ignored
      card_val = 4'($urandom_range(0, 15));
    end else begin
      card_vld = 1'b0;
      card_val = 4'd0;
    end
  endtask

  task automatic press(input int k);
    if (k == 0) btn_m = 1'b1; else btn_r = 1'b1;
    cyc();
    btn_m = 1'b0;
    btn_r = 1'b0;
    cyc();
  endtask

  task automatic wait_phase(input logic [2:0] p, input string tag);
    int g = 0;
    while (phase !== p && g < 500) begin
      cyc();
      g++;
    end
    chk(tag, phase, p);
  endtask

  task automatic rand_deck(input int from);
    for (int i = from; i < DECK; i++) begin
      if ($urandom_range(0, 9) == 0)
        deck_a[i] = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(14, 15);
      else
        deck_a[i] = $urandom_range(1, 13);
    end
  endtask

  task automatic load_deck();
    deck_q.delete();
    for (int i = 0; i < DECK; i++) deck_q.push_back(deck_a[i]);
  endtask

  // Next playable card from the model's copy of the deck, in half-points.
  task automatic m_draw(output int h);
    int v;
    h = 0;
    while (h == 0 && mi < DECK) begin
      v = deck_a[mi];
      mi++;
      if (v >= 1 && v <= 13) h = (v <= 10) ? 2 * v : 1;
      else m_errs++;
    end
  endtask

  // Whole-round outcome from the rules, the deck and each player's hit threshold.
  task automatic model_round();
    int h, all_bust;
    mi = 0; m_errs = 0;
    act_p.delete(); act_k.delete();
    for (int p = 0; p < NP; p++) begin
      m_draw(h); m_s[p] = h; m_c[p] = 1; m_b[p] = 0; m_deal_s[p] = h;
    end
    m_draw(h); m_ds = h; m_deal_ds = h;
    for (int p = 0; p < NP; p++) begin
      while (1) begin
        if (m_s[p] < th[p]) begin
          act_p.push_back(p); act_k.push_back(0);
          m_draw(h); m_s[p] += h; m_c[p]++;
          if (m_s[p] > 21) begin m_b[p] = 1; break; end
          if (m_s[p] == 21 || m_c[p] == 5) break;
        end else begin
          act_p.push_back(p); act_k.push_back(1);
          break;
        end
      end
    end
    all_bust = 1;
    for (int p = 0; p < NP; p++) if (m_b[p] == 0) all_bust = 0;
    if (all_bust == 0) while (m_ds < 14) begin m_draw(h); m_ds += h; end
    m_db = (m_ds > 21) ? 1 : 0;
    for (int p = 0; p < NP; p++)
      m_w[p] = (m_b[p] == 0 && (m_c[p] == 5 || m_db == 1 || m_s[p] > m_ds)) ? 1 : 0;
    m_used = mi;
  endtask

  task automatic play_round(input string tag);
    int g = 0;
    bit dealt = 1'b0;
    int k;
    model_round();
    load_deck();
    rd_cnt = 0; err_cnt = 0;
    press(0);
    while (phase !== 3'd6 && g < 3000) begin
      if (phase === 3'd2 && !dealt) begin
        dealt = 1'b1;
        for (int p = 0; p < NP; p++) begin
          chk($sformatf("%s_deal_score%0d", tag, p), player_score[p*7 +: 7], m_deal_s[p]);
          chk($sformatf("%s_deal_cnt%0d", tag, p), player_cnt[p*3 +: 3], 1);
        end
        chk($sformatf("%s_deal_dealer", tag), dealer_score, m_deal_ds);
      end
      if (phase === 3'd2 && act_p.size() > 0) begin
        chk($sformatf("%s_turn", tag), cur_player, act_p.pop_front());
        k = act_k.pop_front();
        press(k);
      end else begin
        cyc();
      end
      g++;
    end
    chk($sformatf("%s_reach_result", tag), phase, 3'd6);
    repeat (3) cyc();
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("%s_score%0d", tag, p), player_score[p*7 +: 7], m_s[p]);
      chk($sformatf("%s_cnt%0d", tag, p), player_cnt[p*3 +: 3], m_c[p]);
      chk($sformatf("%s_bust%0d", tag, p), bust[p], m_b[p]);
      chk($sformatf("%s_win%0d", tag, p), win[p], m_w[p]);
    end
    chk($sformatf("%s_dealer_score", tag), dealer_score, m_ds);
    chk($sformatf("%s_dealer_bust", tag), dealer_bust, m_db);
    chk($sformatf("%s_round_done", tag), rd_cnt, 1);
    chk($sformatf("%s_card_err", tag), err_cnt, m_errs);
    chk($sformatf("%s_cards_used", tag), DECK - deck_q.size(), m_used);
    chk($sformatf("%s_actions_left", tag), act_p.size(), 0);
  endtask

  initial begin
    rst = 1'b1; btn_m = 1'b0; btn_r = 1'b0; card_vld = 1'b0; card_val = 4'd0;
    cyc(); cyc();
    chk("rst_phase", phase, 3'd0);
    chk("rst_req", card_req, 1'b0);
    chk("rst_pscore", player_score, 0);
    chk("rst_dscore", dealer_score, 0);
    chk("rst_cnt", player_cnt, 0);
    chk("rst_flags", {bust, dealer_bust, win, round_done, card_err, cur_player}, 0);
    rst = 1'b0;

    // Reset while a hit is waiting for its card.
    rand_deck(0);
    deck_a[0] = 2; deck_a[1] = 2; deck_a[2] = 2;
    load_deck();
    press(0);
    wait_phase(3'd2, "mid_play");
    btn_m = 1'b1;
    cyc();
    btn_m = 1'b0;
    chk("mid_draw_phase", phase, 3'd3);
    chk("mid_draw_req", card_req, 1'b1);
    rst = 1'b1; card_vld = 1'b1; card_val = 4'd9;
    @(posedge clk); #1;
    chk("mid_rst_phase", phase, 3'd0);
    chk("mid_rst_req", card_req, 1'b0);
    chk("mid_rst_score", {player_score, dealer_score, player_cnt}, 0);
    rst = 1'b0; card_vld = 1'b1; card_val = 4'd9;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_phase", phase, 3'd0);
    chk("post_rst_req", card_req, 1'b0);
    chk("post_rst_score", {player_score, dealer_score, player_cnt}, 0);
    card_vld = 1'b0;

    // P0 hits to exactly 21 and moves on by itself; dealer stops at 14.
    rand_deck(5);
    deck_a[0] = 10; deck_a[1] = 3; deck_a[2] = 5; deck_a[3] = 11; deck_a[4] = 2;
    th[0] = 21; th[1] = 0;
    play_round("hit21");
    chk("hit21_win_const", win, 2'b01);
    chk("hit21_dealer_const", dealer_score, 7'd14);

    // Every player busts: dealer draws nothing.
    rand_deck(5);
    deck_a[0] = 10; deck_a[1] = 3; deck_a[2] = 5; deck_a[3] = 9; deck_a[4] = 9;
    th[0] = 21; th[1] = 21;
    play_round("allbust");
    chk("allbust_win_const", win, 2'b00);
    chk("allbust_dealer_const", dealer_score, 7'd10);

    // Five face cards: charlie beats a dealer at 21.
    rand_deck(9);
    deck_a[0] = 11; deck_a[1] = 3; deck_a[2] = 5; deck_a[3] = 12; deck_a[4] = 13;
    deck_a[5] = 11; deck_a[6] = 12; deck_a[7] = 11; deck_a[8] = 5;
    th[0] = 21; th[1] = 0;
    play_round("charlie");
    chk("charlie_win_const", win, 2'b01);
    chk("charlie_dealer_const", dealer_score, 7'd21);

    // Invalid ranks during a draw are discarded with card_err.
    rand_deck(6);
    deck_a[0] = 2; deck_a[1] = 3; deck_a[2] = 5; deck_a[3] = 0; deck_a[4] = 14; deck_a[5] = 7;
    th[0] = 10; th[1] = 0;
    play_round("badcard");
    chk("badcard_p0_const", player_score[6:0], 7'd18);

    repeat (20) begin
      rand_deck(0);
      for (int p = 0; p < NP; p++) th[p] = $urandom_range(0, 21);
      play_round("rnd");
    end

    // Hit and stand rising together count as stand; a held hit button does nothing.
    rand_deck(0);
    deck_a[0] = 4; deck_a[1] = 4; deck_a[2] = 4; deck_a[3] = 4;
    load_deck();
    rd_cnt = 0;
    press(0);
    wait_phase(3'd2, "both_play");
    btn_m = 1'b1; btn_r = 1'b1;
    cyc();
    chk("both_phase", phase, 3'd2);
    chk("both_player", cur_player, 2'd1);
    chk("both_req", card_req, 1'b0);
    btn_r = 1'b0;
    repeat (3) cyc();
    chk("held_phase", phase, 3'd2);
    chk("held_req", card_req, 1'b0);
    chk("held_player", cur_player, 2'd1);
    chk("held_cnt", player_cnt, 6'b001001);
    btn_m = 1'b0;
    cyc();
    press(1);
    wait_phase(3'd6, "both_result");
    chk("both_dealer", dealer_score, 7'd16);
    chk("both_win", win, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
